// File: rtl/jstk_direction_encoder_if.sv
// Joystick sample/button inputs and compass-event handshake outputs.
// The slave side is the encoder; the master side drives samples and consumes events.
interface jstk_direction_encoder_if #(
    parameter int unsigned width_p = 10
);
    logic [width_p-1:0] position_x_i;
    logic [width_p-1:0] position_y_i;
    logic               sample_valid_i;
    logic               button_i;
    logic               ready_i;
    logic [1:0]         direction_o;
    logic               valid_o;
    logic [3:0]         deflect_o;
    logic               dropped_o;

    modport master (
        output position_x_i, position_y_i, sample_valid_i, button_i, ready_i,
        input  direction_o, valid_o, deflect_o, dropped_o
    );

    modport slave (
        input  position_x_i, position_y_i, sample_valid_i, button_i, ready_i,
        output direction_o, valid_o, deflect_o, dropped_o
    );
endinterface

// File: rtl/jstk_direction_encoder.sv
// Turns joystick X/Y samples plus a bouncy button into one compass event per
// debounced press, with per-axis hysteresis and a valid/ready handshake.
module jstk_direction_encoder #(
    parameter int unsigned width_p           = 10,
    parameter int unsigned hi_thresh_p       = 640,
    parameter int unsigned lo_thresh_p       = 384,
    parameter int unsigned hyst_p            = 32,
    parameter int unsigned debounce_cycles_p = 120000
) (
    input logic                      clk_i,
    input logic                      reset_n_i,
    jstk_direction_encoder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(debounce_cycles_p + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(debounce_cycles_p);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [width_p-1:0] HI_SET  = width_p'(hi_thresh_p);
    localparam logic [width_p-1:0] HI_CLR  = width_p'(hi_thresh_p - hyst_p);
    localparam logic [width_p-1:0] LO_SET  = width_p'(lo_thresh_p);
    localparam logic [width_p-1:0] LO_CLR  = width_p'(lo_thresh_p + hyst_p);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } btn_state_t;

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press;
    logic             r_press;

    logic             r_left, r_right, r_up, r_down;
    logic [1:0]       r_dir;
    logic             r_valid;
    logic             r_dropped;
    logic [1:0]       w_code;
    logic             w_centred;

    logic [width_p-1:0] w_x;
    logic [width_p-1:0] w_y;

    assign w_x = bus.position_x_i;
    assign w_y = bus.position_y_i;

    // Per-axis hysteresis flags, updated only on new samples.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
        end else if (bus.sample_valid_i) begin
            if (w_x > HI_SET)        r_left  <= 1'b1;
            else if (w_x <= HI_CLR)  r_left  <= 1'b0;
            if (w_x < LO_SET)        r_right <= 1'b1;
            else if (w_x >= LO_CLR)  r_right <= 1'b0;
            if (w_y > HI_SET)        r_up    <= 1'b1;
            else if (w_y <= HI_CLR)  r_up    <= 1'b0;
            if (w_y < LO_SET)        r_down  <= 1'b1;
            else if (w_y >= LO_CLR)  r_down  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press;
        end
    end

    // Debounce FSM: a press fires only on the PRESS_WAIT -> PRESSED transition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        case (r_state)
            ST_RELEASED: begin
                if (bus.button_i) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!bus.button_i) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!bus.button_i) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (bus.button_i) begin
                    w_state_nxt = ST_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Priority: left > right > up > down.
    always_comb begin
        w_code    = 2'b00;
        w_centred = !(r_left || r_right || r_up || r_down);
        if (r_left)       w_code = 2'b10;
        else if (r_right) w_code = 2'b01;
        else if (r_up)    w_code = 2'b00;
        else if (r_down)  w_code = 2'b11;
    end

    // Event slot: a completed handshake frees it; a press either fills it or is dropped.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_dir     <= 2'b00;
            r_valid   <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            if (r_valid && bus.ready_i) begin
                r_valid <= 1'b0;
            end
            if (r_press) begin
                if (w_centred) begin
                    r_dropped <= 1'b1;
                end else if (!r_valid || bus.ready_i) begin
                    r_dir   <= w_code;
                    r_valid <= 1'b1;
                end else begin
                    r_dropped <= 1'b1;
                end
            end
        end
    end

    assign bus.direction_o = r_dir;
    assign bus.valid_o     = r_valid;
    assign bus.deflect_o   = {r_left, r_right, r_down, r_up};
    assign bus.dropped_o   = r_dropped;

endmodule

// File: tb/tb_jstk_direction_encoder.sv
// Scoreboard bench: a behavioural model predicts flags, drops and events;
// a negedge monitor compares DUT outputs and pops accepted events.
module tb_jstk_direction_encoder;
    localparam int unsigned W    = 10;
    localparam int unsigned N    = 4;
    localparam int          HI   = 640;
    localparam int          LO   = 384;
    localparam int          HYST = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    jstk_direction_encoder_if #(.width_p(W)) bus ();

    jstk_direction_encoder #(
        .width_p(W), .hi_thresh_p(HI), .lo_thresh_p(LO),
        .hyst_p(HYST), .debounce_cycles_p(N)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus.slave)
    );

    // Reference model state
    bit       m_l, m_r, m_u, m_d;
    bit       m_valid, m_drop, m_press, m_deb;
    int       m_run;
    logic [1:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hi_flag(input bit cur, input int v);
        if (v > HI) return 1'b1;
        if (v <= HI - HYST) return 1'b0;
        return cur;
    endfunction

    function automatic bit lo_flag(input bit cur, input int v);
        if (v < LO) return 1'b1;
        if (v >= LO + HYST) return 1'b0;
        return cur;
    endfunction

    function automatic logic [1:0] pick_code();
        if (m_l) return 2'b10;
        if (m_r) return 2'b01;
        if (m_u) return 2'b00;
        return 2'b11;
    endfunction

    // Model: button debounced as "N+1 consecutive opposite samples flip the level".
    always @(posedge clk or negedge rst_n) begin
        bit nv, nd;
        if (!rst_n) begin
            {m_l, m_r, m_u, m_d} = 4'b0;
            m_valid = 0; m_drop = 0; m_press = 0; m_deb = 0; m_run = 0;
            exp_q.delete();
        end else begin
            nv = m_valid;
            nd = 0;
            if (m_valid && bus.ready_i) nv = 0;
            if (m_press) begin
                if (!(m_l || m_r || m_u || m_d)) nd = 1;
                else if (!m_valid || bus.ready_i) begin
                    nv = 1;
                    exp_q.push_back(pick_code());
                end else nd = 1;
            end
            m_valid = nv;
            m_drop  = nd;
            if (bus.sample_valid_i) begin
                m_l = hi_flag(m_l, int'(bus.position_x_i));
                m_r = lo_flag(m_r, int'(bus.position_x_i));
                m_u = hi_flag(m_u, int'(bus.position_y_i));
                m_d = lo_flag(m_d, int'(bus.position_y_i));
            end
            m_press = 0;
            if (bus.button_i == m_deb) m_run = 0;
            else begin
                m_run++;
                if (m_run == int'(N) + 1) begin
                    m_deb   = bus.button_i;
                    m_run   = 0;
                    m_press = bus.button_i;
                end
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", int'(bus.valid_o), int'(m_valid));
            chk("deflect", int'(bus.deflect_o), int'({m_l, m_r, m_d, m_u}));
            chk("dropped", int'(bus.dropped_o), int'(m_drop));
            if (bus.valid_o) begin
                if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    chk("direction", int'(bus.direction_o), int'(exp_q[0]));
                    if (bus.ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int x, input int y);
        bus.position_x_i   = W'(x);
        bus.position_y_i   = W'(y);
        bus.sample_valid_i = 1'b1;
        step();
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic press(input int len, output int drops, output int events);
        drops = 0;
        events = 0;
        bus.button_i = 1'b1;
        for (int i = 0; i < len + int'(N) + 4; i++) begin
            if (i == len) bus.button_i = 1'b0;
            step();
            if (bus.dropped_o) drops++;
            if (bus.valid_o && bus.ready_i) events++;
        end
    endtask

    function automatic int pick_pos();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 1023));
            1:       return int'($urandom_range(600, 680));
            2:       return int'($urandom_range(340, 430));
            default: return 512;
        endcase
    endfunction

    initial begin
        int k, drops, events;
        bus.position_x_i = W'(512);
        bus.position_y_i = W'(512);
        bus.sample_valid_i = 1'b0;
        bus.button_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (3) step();
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_deflect", int'(bus.deflect_o), 0);
        chk("rst_dropped", int'(bus.dropped_o), 0);
        chk("rst_direction", int'(bus.direction_o), 0);
        rst_n = 1'b1;
        step();

        // Left press: valid rises 6 cycles after the button rises
        sample(700, 512);
        bus.button_i = 1'b1;
        k = 0;
        while (!bus.valid_o && k < 20) begin
            step();
            k++;
        end
        chk("latency", k, int'(N) + 2);
        chk("dir_left", int'(bus.direction_o), 2);
        step();
        chk("one_cycle_valid", int'(bus.valid_o), 0);
        repeat (3) step();
        bus.button_i = 1'b0;
        repeat (N + 4) step();

        // Hysteresis on left
        sample(700, 512);
        chk("left_set", int'(bus.deflect_o[3]), 1);
        sample(620, 512);
        chk("left_hold", int'(bus.deflect_o[3]), 1);
        sample(608, 512);
        chk("left_clear", int'(bus.deflect_o[3]), 0);

        // Centred press is dropped
        sample(512, 512);
        press(N + 3, drops, events);
        chk("centred_drops", drops, 1);
        chk("centred_events", events, 0);

        // Overrun with ready low
        bus.ready_i = 1'b0;
        sample(100, 512);
        press(N + 3, drops, events);
        chk("ovr_first_drops", drops, 0);
        chk("ovr_valid", int'(bus.valid_o), 1);
        press(N + 3, drops, events);
        chk("ovr_second_drops", drops, 1);
        chk("ovr_dir_right", int'(bus.direction_o), 1);
        bus.ready_i = 1'b1;
        step();
        chk("ovr_release", int'(bus.valid_o), 0);

        // Bouncing button: toggling every 2 cycles never debounces
        drops = 0;
        events = 0;
        for (int i = 0; i < 20; i++) begin
            bus.button_i = ((i / 2) % 2 == 0);
            step();
            if (bus.dropped_o) drops++;
            if (bus.valid_o) events++;
        end
        bus.button_i = 1'b0;
        repeat (N + 4) step();
        chk("bounce_events", events, 0);
        chk("bounce_drops", drops, 0);

        // Reset while in PRESS_WAIT with an event pending
        bus.ready_i = 1'b0;
        sample(700, 512);
        press(N + 3, drops, events);
        bus.button_i = 1'b1;
        repeat (2) step();
        chk("pre_reset_valid", int'(bus.valid_o), 1);
        #2;
        rst_n = 1'b0;
        bus.button_i = 1'b0;
        #1;
        chk("async_rst_valid", int'(bus.valid_o), 0);
        chk("async_rst_deflect", int'(bus.deflect_o), 0);
        step();
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        events = 0;
        for (int i = 0; i < int'(N) + 6; i++) begin
            step();
            if (bus.valid_o) events++;
        end
        chk("post_reset_events", events, 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bus.position_x_i   = W'(pick_pos());
            bus.position_y_i   = W'(pick_pos());
            bus.sample_valid_i = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) bus.button_i = ~bus.button_i;
            bus.ready_i        = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.sample_valid_i = 1'b0;
        bus.button_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (N + 8) step();
        chk("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
